// File: rtl/or3_rr_arbiter_if.sv
// Requester-side bundle for the three-way round-robin arbiter.
// Latency: none (wires only); grant/owner/busy are registered inside the arbiter.
// Backpressure: a requester holds req high until it sees its grant bit and finishes its use.
//
// Signals:
//   req[2:0]    per-requester level request, driven by the requesting units
//   grant[2:0]  one-hot owner select (000 = resource idle)
//   owner[1:0]  encoded owner 0..2, 3 = none
//   busy        OR of grant
//   any_req     combinational OR of req, scheduler wake-up term
interface or3_rr_arbiter_if;
  logic [2:0] req;
  logic [2:0] grant;
  logic [1:0] owner;
  logic       busy;
  logic       any_req;

  // Requesting side: drives req, observes the arbiter decision.
  modport master (
    output req,
    input  grant,
    input  owner,
    input  busy,
    input  any_req
  );

  // Arbiter side.
  modport slave (
    input  req,
    output grant,
    output owner,
    output busy,
    output any_req
  );
endinterface

// File: rtl/or3_rr_arbiter.sv
// Round-robin arbiter giving one 3-input OR resource to one of three requesters at a time.
// Latency: 1 cycle from req sampled high to grant visible; handoffs are back-to-back.
// Backpressure: losers simply keep req high (pending) until rotated in; no queueing.
//
// Ports:
//   clk, rst_n       rising-edge clock, asynchronous active-low reset
//   bus (slave)      req[2:0] in; grant[2:0], owner[1:0], busy, any_req out
// Parameters:
//   MAX_HOLD (2..15) longest consecutive ownership while others wait (timeout build only)
//   CNT_W            hold counter width, 2**CNT_W > MAX_HOLD
// Optional feature macro: ARB_TIMEOUT_EN enables hold-counter preemption.
module or3_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned CNT_W    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  or3_rr_arbiter_if.slave   bus
);

  // Reject configurations the hold counter cannot represent.
  if ((MAX_HOLD < 2) || (MAX_HOLD > 15) || ((32'd1 << CNT_W) <= MAX_HOLD)) begin : g_bad_cfg
    $error("or3_rr_arbiter: MAX_HOLD must be 2..15 and fit in CNT_W bits");
  end

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [1:0] NO_OWNER = 2'd3;

  state_t     state_q, state_d;
  logic [2:0] grant_q, grant_d;
  logic [1:0] owner_q, owner_d;
  logic [1:0] last_q,  last_d;
  logic       busy_q,  busy_d;

  logic [2:0] others;      // pending requests other than the current owner
  logic       owner_held;  // current owner still asserting its request
  logic       preempt;     // hold limit reached while someone else waits
  logic [1:0] win_any;     // winner over all requests (used from IDLE)
  logic [1:0] win_other;   // winner excluding the current owner (used from GRANT)

  // Rotating search starting just after ptr; returns NO_OWNER if cand is empty.
  function automatic logic [1:0] rr_pick(input logic [2:0] cand, input logic [1:0] ptr);
    logic [1:0] idx;
    logic [1:0] pick;
    pick = NO_OWNER;
    idx  = (ptr == 2'd2) ? 2'd0 : ptr + 2'd1;
    for (int k = 0; k < 3; k++) begin
      if ((pick == NO_OWNER) && cand[idx]) begin
        pick = idx;
      end
      idx = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    end
    return pick;
  endfunction

  function automatic logic [2:0] to_onehot(input logic [1:0] idx);
    logic [2:0] oh;
    case (idx)
      2'd0:    oh = 3'b001;
      2'd1:    oh = 3'b010;
      2'd2:    oh = 3'b100;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

  assign bus.any_req = bus.req[0] | bus.req[1] | bus.req[2];

  assign others     = bus.req & ~grant_q;
  assign owner_held = |(bus.req & grant_q);

  // In GRANT, last_q always equals the owner, so one pointer serves both searches.
  assign win_any   = rr_pick(bus.req, last_q);
  assign win_other = rr_pick(others,  last_q);

`ifdef ARB_TIMEOUT_EN
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  logic [CNT_W-1:0] hold_q, hold_d;

  assign preempt = (state_q == GRANT) && (hold_q == HOLD_LAST) && (|others);

  // Counts cycles the current owner has been retained; any ownership change
  // (grant from idle, handoff, preemption, release) restarts it at zero.
  always_comb begin
    hold_d = '0;
    if ((state_q == GRANT) && owner_held && !preempt) begin
      hold_d = (hold_q == HOLD_LAST) ? hold_q : hold_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end
`else
  // Ownership ends only when the owner drops its request.
  assign preempt = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    last_d  = last_q;
    busy_d  = busy_q;
    case (state_q)
      IDLE: begin
        if (bus.any_req) begin
          state_d = GRANT;
          owner_d = win_any;
          grant_d = to_onehot(win_any);
          last_d  = win_any;
          busy_d  = 1'b1;
        end
      end
      GRANT: begin
        if (owner_held && !preempt) begin
          // Keep ownership; a one-cycle drop between edges is never seen.
          state_d = GRANT;
        end else if (|others) begin
          // Direct handoff, no idle cycle in between.
          owner_d = win_other;
          grant_d = to_onehot(win_other);
          last_d  = win_other;
          busy_d  = 1'b1;
        end else begin
          // Release; last_q keeps the old owner so it goes to the back of the line.
          state_d = IDLE;
          owner_d = NO_OWNER;
          grant_d = 3'b000;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        owner_d = NO_OWNER;
        grant_d = 3'b000;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= 3'b000;
      owner_q <= NO_OWNER;
      last_q  <= 2'd2;     // requester 0 searched first after reset
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.grant = grant_q;
  assign bus.owner = owner_q;
  assign bus.busy  = busy_q;

endmodule
